// File: rtl/alu.sv
// 64-bit LEGv8-style integer ALU with registered result; z = f(a,b,s) one cycle after inputs.
// Optional registered {N,Z,C,V} flags port when ALU_FLAGS_EN is defined; no handshake.
module alu #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       s,
`ifdef ALU_FLAGS_EN
    output logic [3:0]       flags,
`endif
    output logic [WIDTH-1:0] z
);
    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] r_z;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_add;
    logic [WIDTH-1:0] w_sub;
    logic [SHW-1:0]   w_sh;
    logic             w_slt;
    logic             w_sltu;

    assign w_sh   = b[SHW-1:0];
    assign w_slt  = $signed(a) < $signed(b);
    assign w_sltu = a < b;

`ifdef ALU_FLAGS_EN
    logic       w_add_c;
    logic       w_sub_c;
    logic       w_c;
    logic       w_v;
    logic [3:0] r_flags;

    // Subtraction carry is the ARM "no borrow" sense, falling out of a + ~b + 1.
    assign {w_add_c, w_add} = {1'b0, a} + {1'b0, b};
    assign {w_sub_c, w_sub} = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
`else
    assign w_add = a + b;
    assign w_sub = a + ~b + WIDTH'(1);
`endif

    always_comb begin
        w_res = '0;
        case (s)
            4'b0000: w_res = a & b;
            4'b0001: w_res = a | b;
            4'b0010: w_res = w_add;
            4'b0011: w_res = a ^ b;
            4'b0100: w_res = a << w_sh;
            4'b0101: w_res = a >> w_sh;
            4'b0110: w_res = w_sub;
            4'b0111: w_res = b;
            4'b1000: w_res = WIDTH'($signed(a) >>> w_sh);
            4'b1001: w_res = a & ~b;
            4'b1010: w_res = a | ~b;
            4'b1011: w_res = {{(WIDTH-1){1'b0}}, w_slt};
            4'b1100: w_res = ~(a | b);
            4'b1101: w_res = {{(WIDTH-1){1'b0}}, w_sltu};
            4'b1110: w_res = a;
            4'b1111: w_res = ~b;
            default: w_res = '0;
        endcase
    end

`ifdef ALU_FLAGS_EN
    always_comb begin
        w_c = 1'b0;
        w_v = 1'b0;
        if (s == 4'b0010) begin
            w_c = w_add_c;
            w_v = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
        end else if (s == 4'b0110) begin
            w_c = w_sub_c;
            w_v = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= 4'b0000;
        end else begin
            r_flags <= {w_res[WIDTH-1], (w_res == '0), w_c, w_v};
        end
    end

    assign flags = r_flags;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_z <= '0;
        end else begin
            r_z <= w_res;
        end
    end

    assign z = r_z;
endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: driver pushes hand-computed results per cycle, monitor pops after each edge
// and also confirms z holds once inputs change mid-cycle. Flag checks are active with ALU_FLAGS_EN.
module tb_alu;
    logic        clk;
    logic        reset;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  s;
    logic [63:0] z;
`ifdef ALU_FLAGS_EN
    logic [3:0]  flags;
`endif

    typedef struct {
        logic [63:0] z;
        logic [3:0]  f;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   drv_done = 0;

    alu dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .s     (s),
`ifdef ALU_FLAGS_EN
        .flags (flags),
`endif
        .z     (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply(input logic r, input logic [63:0] ta, input logic [63:0] tb_,
                         input logic [3:0] ts, input logic [63:0] ez, input logic [3:0] ef,
                         input string nm);
        exp_t e;
        @(negedge clk);
        reset = r;
        a     = ta;
        b     = tb_;
        s     = ts;
        e.z = ez;
        e.f = ef;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: compare after each rising edge, then re-check z once the driver has moved inputs.
    initial begin
        exp_t cur;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                cur = exp_q.pop_front();
                total++;
                if (z !== cur.z) begin
                    bad++;
                    $display("FAIL %s: z=%h expected %h", cur.name, z, cur.z);
                end
`ifdef ALU_FLAGS_EN
                total++;
                if (flags !== cur.f) begin
                    bad++;
                    $display("FAIL %s flags: got %b expected %b", cur.name, flags, cur.f);
                end
`endif
                @(negedge clk);
                #2;
                total++;
                if (z !== cur.z) begin
                    bad++;
                    $display("FAIL %s hold: z=%h expected %h", cur.name, z, cur.z);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        a = '1;
        b = 64'd1;
        s = 4'b0010;
        apply(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010, 64'h0, 4'b0000, "reset0");
        apply(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010, 64'h0, 4'b0000, "reset1");
        apply(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010, 64'h0, 4'b0110, "add_wrap");
        apply(0, 64'h0, 64'd1, 4'b1100, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, "nor");
        apply(0, 64'd5, 64'd7, 4'b0110, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, "sub_borrow");
        apply(0, 64'd5, 64'd7, 4'b1011, 64'd1, 4'b0000, "slt");
        apply(0, 64'd5, 64'd7, 4'b1101, 64'd1, 4'b0000, "sltu");
        apply(0, 64'h8000_0000_0000_0000, 64'h43, 4'b1000, 64'hF000_0000_0000_0000, 4'b1000, "asr");
        apply(0, 64'h8000_0000_0000_0000, 64'h43, 4'b0101, 64'h1000_0000_0000_0000, 4'b0000, "lsr");
        apply(0, 64'd1, 64'd63, 4'b0100, 64'h8000_0000_0000_0000, 4'b1000, "lsl63");
        apply(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010, 64'h8000_0000_0000_0000, 4'b1001, "add_ovf");
        apply(0, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 4'b0000, 64'hF000_F000_F000_F000, 4'b1000, "and");
        apply(0, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 4'b0001, 64'hFFF0_FFF0_FFF0_FFF0, 4'b1000, "orr");
        apply(0, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 4'b0011, 64'h0FF0_0FF0_0FF0_0FF0, 4'b0000, "eor");
        apply(0, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 4'b1001, 64'h00F0_00F0_00F0_00F0, 4'b0000, "bic");
        apply(0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1010, 64'h0, 4'b0100, "orn");
        apply(0, 64'h55, 64'h0, 4'b1111, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, "mvn");
        apply(0, 64'd3, 64'd3, 4'b0110, 64'h0, 4'b0110, "sub_eq");
        apply(0, 64'h8000_0000_0000_0000, 64'd1, 4'b0110, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011, "sub_ovf");
        apply(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b1011, 64'd1, 4'b0000, "slt_neg");
        apply(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b1101, 64'd0, 4'b0100, "sltu_big");
        apply(0, 64'h1234, 64'h40, 4'b0100, 64'h1234, 4'b0000, "lsl_by0");
        apply(0, 64'h4000_0000_0000_0000, 64'd1, 4'b1000, 64'h2000_0000_0000_0000, 4'b0000, "asr_pos");
        apply(0, 64'hABCD, 64'h1234, 4'b0111, 64'h1234, 4'b0000, "passb");
        apply(0, 64'hABCD, 64'h1234, 4'b1110, 64'hABCD, 4'b0000, "passa");
        apply(1, 64'hABCD, 64'h1234, 4'b0010, 64'h0, 4'b0000, "reset_mid");
        apply(0, 64'd2, 64'd3, 4'b0010, 64'd5, 4'b0000, "add_after_rst");
        drv_done = 1;
        repeat (4) @(posedge clk);
        #3;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d entries left expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: driver_done=%0d expected 1", drv_done);
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule
